// File: rtl/keypad_pkg.sv
// ============================================================================
// Package : keypad_pkg
// Shared sizes, debounce state codes and scan-result classes for the keypad.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef logic [1:0] kp_state_t;
  localparam kp_state_t IDLE     = 2'd0;
  localparam kp_state_t DEBOUNCE = 2'd1;
  localparam kp_state_t HELD     = 2'd2;
  localparam kp_state_t RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_class_e;

endpackage

`default_nettype wire

// File: rtl/keypad_debouncer.sv
// ============================================================================
// Module : keypad_debouncer
// Scan-rate debounce FSM turning classified full scans into key events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_eval,
  input  scan_class_e      i_class,
  input  logic [KEY_W-1:0] i_key,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_held
);

  localparam logic [3:0] c_scans = 4'(DEBOUNCE_SCANS);

  kp_state_t        r_state;
  logic [KEY_W-1:0] r_cand;
  logic [3:0]       r_stable;
  logic [3:0]       r_rel;
  logic [KEY_W-1:0] r_code;
  logic             r_valid;
  logic             r_held;

  logic w_single;
  assign w_single = (i_class == SCAN_SINGLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cand   <= '0;
      r_stable <= 4'd0;
      r_rel    <= 4'd0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_eval) begin
        case (r_state)
          IDLE: begin
            if (w_single) begin
              r_state  <= DEBOUNCE;
              r_cand   <= i_key;
              r_stable <= 4'd1;
            end
          end
          DEBOUNCE: begin
            if (w_single && (i_key == r_cand)) begin
              r_stable <= r_stable + 4'd1;
              if ((r_stable + 4'd1) == c_scans) begin
                r_state <= HELD;
                r_code  <= r_cand;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
              end
            end else if (w_single) begin
              r_cand   <= i_key;
              r_stable <= 4'd1;
            end else begin
              r_state <= IDLE;
            end
          end
          HELD: begin
            if (!(w_single && (i_key == r_code))) begin
              r_state <= RELEASE;
              r_rel   <= (i_class == SCAN_NONE) ? 4'd1 : 4'd0;
            end
          end
          RELEASE: begin
            // Only an unbroken run of empty scans ends a hold; ghosts or
            // other keys restart the count so no new key sneaks in.
            if (i_class == SCAN_NONE) begin
              r_rel <= r_rel + 4'd1;
              if ((r_rel + 4'd1) == c_scans) begin
                r_state <= IDLE;
                r_held  <= 1'b0;
              end
            end else if (w_single && (i_key == r_code)) begin
              r_state <= HELD;
            end else begin
              r_rel <= 4'd0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_key_code  = r_code;
  assign o_key_valid = r_valid;
  assign o_key_held  = r_held;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module : keypad_scanner
// 4x4 keypad column scanner with ghost rejection and debounced key events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL_BITS     = 14,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int c_keys = NUM_ROWS * NUM_COLS;

  logic [NUM_ROWS-1:0]   r_row_s1;
  logic [NUM_ROWS-1:0]   r_row_s2;
  logic [DWELL_BITS-1:0] r_dwell;
  logic [1:0]            r_col_idx;
  logic [c_keys-1:0]     r_pressed;

  logic              w_dwell_end;
  logic              w_eval;
  logic [c_keys-1:0] w_vec;
  logic [4:0]        w_cnt;
  logic [KEY_W-1:0]  w_idx;
  scan_class_e       w_class;

  assign w_dwell_end = &r_dwell;
  assign w_eval      = w_dwell_end && (r_col_idx == 2'd3);
  assign col_n       = ~(4'b1000 >> r_col_idx);

  // Full-scan view including the column being sampled this cycle, so the
  // classifier sees all 16 keys on the evaluating sample itself.
  for (genvar i = 0; i < c_keys; i++) begin : g_vec
    assign w_vec[i] = (r_col_idx == 2'(i % NUM_COLS)) ? ~r_row_s2[i / NUM_COLS]
                                                      : r_pressed[i];
  end

  always_comb begin
    w_cnt = 5'd0;
    w_idx = '0;
    for (int i = 0; i < c_keys; i++) begin
      if (w_vec[i]) begin
        w_cnt = w_cnt + 5'd1;
        w_idx = KEY_W'(i);
      end
    end
    w_class = SCAN_NONE;
    if (w_cnt == 5'd1)     w_class = SCAN_SINGLE;
    else if (w_cnt > 5'd1) w_class = SCAN_MULTI;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_row_s1  <= 4'b1111;
      r_row_s2  <= 4'b1111;
      r_dwell   <= '0;
      r_col_idx <= 2'd0;
      r_pressed <= '0;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      r_dwell  <= r_dwell + DWELL_BITS'(1);
      if (w_dwell_end) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_pressed <= w_eval ? '0 : w_vec;
      end
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_eval      (w_eval),
    .i_class     (w_class),
    .i_key       (w_idx),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .o_key_held  (key_held)
  );

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module : tb_keypad_scanner
// Scan-level scoreboard bench for keypad_scanner with a history-based model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  localparam int DW   = 3;
  localparam int DS   = 3;
  localparam int SCAN = 4 * (1 << DW);

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int passes = 0;
  int exp_q[$];

  // Model: the result of the latest scan and how many scans in a row it repeated.
  int m_last = -3;
  int m_run  = 0;
  int m_code = 0;
  bit m_held = 1'b0;
  bit m_acc  = 1'b0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .DWELL_BITS     (DW),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_n[3-c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // -1 = no key, -2 = several keys, otherwise the single key index.
  function automatic int classify(input logic [15:0] k);
    int idx;
    idx = 0;
    if (k == 16'h0000) return -1;
    if ($countones(k) != 1) return -2;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    m_last = -3;
    m_run  = 0;
    m_code = 0;
    m_held = 1'b0;
    m_acc  = 1'b0;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int res;
    res = classify(k);
    if (res == m_last) m_run++;
    else begin
      m_last = res;
      m_run  = 1;
    end
    m_acc = 1'b0;
    if (!m_held && res >= 0 && m_run == DS) begin
      m_acc  = 1'b1;
      m_held = 1'b1;
      m_code = res;
      exp_q.push_back(res);
    end else if (m_held && res == -1 && m_run == DS) begin
      m_held = 1'b0;
    end
  endtask

  task automatic end_checks();
    check("key_held", int'(key_held), int'(m_held));
    check("key_valid_timing", int'(key_valid), int'(m_acc));
    check("key_code", int'(key_code), m_code);
  endtask

  task automatic run_scan(input logic [15:0] k);
    @(negedge clock);
    keys = k;
    model_scan(k);
    repeat (SCAN) @(posedge clock);
    #1;
    end_checks();
  endtask

  task automatic run_scans(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_scan(k);
  endtask

  // Reset, then run the first post-reset scan with keys k.
  task automatic do_reset(input logic [15:0] k);
    @(negedge clock);
    reset_n = 1'b0;
    keys = k;
    #1;
    check("rst_col_n", int'(col_n), 7);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    check("rst_key_code", int'(key_code), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    model_scan(k);
    repeat (7) @(posedge clock);
    #1;
    check("col0_after_7", int'(col_n), 7);
    repeat (2) @(posedge clock);
    #1;
    check("col1_after_9", int'(col_n), 11);
    repeat (SCAN - 9) @(posedge clock);
    #1;
    end_checks();
  endtask

  always @(negedge clock) begin
    int e;
    if (reset_n === 1'b1 && key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: key_code %0d with no accepted key expected at %0t",
                 key_code, $time);
      end else begin
        e = exp_q.pop_front();
        check("valid_key_code", int'(key_code), e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cur;
    int sel;

    // Reset in the middle of a scan, then idle.
    repeat (5) @(posedge clock);
    do_reset(16'h0000);
    run_scan(16'h0000);
    repeat (13) @(posedge clock);
    do_reset(16'h0000);

    // Single press of row 2, col 1 (key 9), then release.
    run_scans(16'h0200, 5);
    run_scans(16'h0000, 4);

    // Bouncing key 5, then steady hold.
    run_scan(16'h0020);
    run_scan(16'h0000);
    run_scan(16'h0020);
    run_scan(16'h0000);
    run_scans(16'h0020, 4);
    run_scans(16'h0000, 4);

    // Ghosting with keys 0 and 5, then key 0 alone.
    run_scans(16'h0021, 10);
    run_scans(16'h0001, 4);
    run_scans(16'h0000, 4);

    // Rollover from key 12 to key 3, release, press key 3 again.
    run_scans(16'h1000, 4);
    run_scans(16'h0008, 3);
    run_scans(16'h0000, 3);
    run_scans(16'h0008, 4);
    run_scans(16'h0000, 4);

    // Reset after two matching scans of key 6, press still held.
    run_scans(16'h0040, 2);
    repeat (13) @(posedge clock);
    do_reset(16'h0040);
    run_scans(16'h0040, 3);
    run_scans(16'h0000, 4);

    // Randomized scan patterns, biased to repeat so keys get accepted.
    cur = 16'h0000;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 5 && sel < 7) cur = 16'h0000;
      else if (sel >= 7 && sel < 9) cur = 16'(1) << $urandom_range(0, 15);
      else if (sel == 9) cur = (16'(1) << $urandom_range(0, 15)) |
                               (16'(1) << $urandom_range(0, 15));
      run_scan(cur);
    end
    run_scans(16'h0000, 4);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
